// File: rtl/maxi_read_arbiter_if.sv
// Bundle of requester streams and the shared AXI3 read port (AR + R) used by
// maxi_read_arbiter. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding logic (requesters and AXI slave).
interface maxi_read_arbiter_if #(
   parameter int NUM_PORTS = 2
);
   logic [NUM_PORTS*33-1:0] REQ_ADDR;
   logic [NUM_PORTS-1:0]    REQ_ADDR_ready;
   logic [NUM_PORTS*65-1:0] RESP_DATA;
   logic [NUM_PORTS-1:0]    RESP_DATA_ready;
   logic [32:0]             MAXI_ARADDR;
   logic                    MAXI_ARADDR_ready;
   logic [3:0]              MAXI_ARLEN;
   logic [1:0]              MAXI_ARSIZE;
   logic [1:0]              MAXI_ARBURST;
   logic [64:0]             MAXI_RDATA;
   logic                    MAXI_RDATA_ready;
   logic [1:0]              MAXI_RRESP;
   logic                    MAXI_RLAST;
   logic                    ERR;

   modport master (
      input  REQ_ADDR,
      input  RESP_DATA_ready,
      input  MAXI_ARADDR_ready,
      input  MAXI_RDATA,
      input  MAXI_RRESP,
      input  MAXI_RLAST,
      output REQ_ADDR_ready,
      output RESP_DATA,
      output MAXI_ARADDR,
      output MAXI_ARLEN,
      output MAXI_ARSIZE,
      output MAXI_ARBURST,
      output MAXI_RDATA_ready,
      output ERR
   );

   modport slave (
      output REQ_ADDR,
      output RESP_DATA_ready,
      output MAXI_ARADDR_ready,
      output MAXI_RDATA,
      output MAXI_RRESP,
      output MAXI_RLAST,
      input  REQ_ADDR_ready,
      input  RESP_DATA,
      input  MAXI_ARADDR,
      input  MAXI_ARLEN,
      input  MAXI_ARSIZE,
      input  MAXI_ARBURST,
      input  MAXI_RDATA_ready,
      input  ERR
   );
endinterface

// File: rtl/maxi_read_arbiter.sv
// Round-robin arbiter sharing one 64-bit AXI3 read master port among
// NUM_PORTS burst requesters. Only one burst is outstanding at a time; every
// burst is BURST_LEN beats long. RLAST placement, RRESP and address alignment
// are checked and any violation raises a sticky ERR that only reset clears.
module maxi_read_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int BURST_LEN = 16
) (
   input  logic IP_CLK,
   input  logic IP_RESET,
   maxi_read_arbiter_if.master bus
);

   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   localparam logic [3:0]  LAST_BEAT   = 4'(BURST_LEN - 1);
   localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);

   logic [1:0]    r_state;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] r_lastGrant;
   logic [31:0]   r_addrQ;
   logic [3:0]    r_beatCnt;
   logic          r_errQ;

   logic [NUM_PORTS-1:0] w_reqValid;
   logic [GW-1:0]        w_winner;
   logic                 w_winnerValid;
   logic [31:0]          w_winnerAddr;
   logic                 w_accept;
   logic                 w_misaligned;
   logic                 w_rValid;
   logic                 w_rReady;
   logic                 w_beat;
   logic                 w_lastBeat;
   logic                 w_beatErr;

   // Pull the valid bit of every requester out of the packed address bus
   always_comb begin
      w_reqValid = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_reqValid[p] = bus.REQ_ADDR[p*33 + 32];
      end
   end

   // Round-robin scan starting just after the last granted port
   always_comb begin
      int scanIdx;
      scanIdx       = 0;
      w_winner      = '0;
      w_winnerValid = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         scanIdx = (int'(r_lastGrant) + k) % NUM_PORTS;
         if (!w_winnerValid && w_reqValid[scanIdx]) begin
            w_winnerValid = 1'b1;
            w_winner      = GW'(scanIdx);
         end
      end
   end

   // Select the winner's byte address without a variable-width part-select
   always_comb begin
      w_winnerAddr = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_winner == GW'(p)) begin
            w_winnerAddr = bus.REQ_ADDR[p*33 +: 32];
         end
      end
   end

   // A request is taken only in IDLE; reset blocks acceptance in the same cycle
   always_comb begin
      w_accept     = (r_state == S_IDLE) && w_winnerValid && !IP_RESET;
      w_misaligned = (w_winnerAddr[2:0] != 3'b000) ||
                     ((w_winnerAddr % BURST_BYTES) != 32'd0);
   end

   // Address-channel ready goes only to the winning port while IDLE
   always_comb begin
      bus.REQ_ADDR_ready = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         bus.REQ_ADDR_ready[p] = w_accept && (w_winner == GW'(p));
      end
   end

   // R channel handshake follows the granted requester, only during DATA
   always_comb begin
      w_rValid   = bus.MAXI_RDATA[64];
      w_rReady   = (r_state == S_DATA) && bus.RESP_DATA_ready[r_grant];
      w_beat     = w_rValid && w_rReady;
      w_lastBeat = (r_beatCnt == LAST_BEAT);
      w_beatErr  = (bus.MAXI_RRESP != 2'b00) ||
                   (w_lastBeat && !bus.MAXI_RLAST) ||
                   (!w_lastBeat && bus.MAXI_RLAST);
   end

   // Forward beats to the granted port only; others see valid=0 and zero data
   always_comb begin
      bus.RESP_DATA = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if ((r_state == S_DATA) && (r_grant == GW'(p))) begin
            bus.RESP_DATA[p*65 +: 65] = bus.MAXI_RDATA;
         end
      end
   end

   // Fixed burst shape plus registered AR request and sticky error
   always_comb begin
      bus.MAXI_ARADDR      = {(r_state == S_ADDR), r_addrQ};
      bus.MAXI_ARLEN       = LAST_BEAT;
      bus.MAXI_ARSIZE      = 2'b11;
      bus.MAXI_ARBURST     = 2'b01;
      bus.MAXI_RDATA_ready = w_rReady;
      bus.ERR              = r_errQ;
   end

   // Main FSM: IDLE grants, ADDR holds AR until accepted, DATA counts beats
   always_ff @(posedge IP_CLK) begin
      if (IP_RESET) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_lastGrant <= GW'(NUM_PORTS - 1);
         r_addrQ     <= '0;
         r_beatCnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_grant     <= w_winner;
                  r_lastGrant <= w_winner;
                  r_addrQ     <= {w_winnerAddr[31:3], 3'b000};
                  r_state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (bus.MAXI_ARADDR_ready) begin
                  r_beatCnt <= '0;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_beat) begin
                  r_beatCnt <= r_beatCnt + 4'd1;
                  if (w_lastBeat) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky error: misaligned request or bad RLAST/RRESP on any beat
   always_ff @(posedge IP_CLK) begin
      if (IP_RESET) begin
         r_errQ <= 1'b0;
      end else if ((w_accept && w_misaligned) || (w_beat && w_beatErr)) begin
         r_errQ <= 1'b1;
      end
   end

endmodule

// File: tb/tb_maxi_read_arbiter.sv
// Directed testbench for maxi_read_arbiter with two requesters and 16-beat
// bursts. The bench plays both the requesters and the AXI read slave.
module tb_maxi_read_arbiter;

   localparam int NP = 2;
   localparam int BL = 16;

   logic IP_CLK;
   logic IP_RESET;

   int checkCount;
   int errorCount;
   int lastG;
   bit errModel;

   maxi_read_arbiter_if #(.NUM_PORTS(NP)) bus ();

   maxi_read_arbiter #(
      .NUM_PORTS(NP),
      .BURST_LEN(BL)
   ) dut (
      .IP_CLK   (IP_CLK),
      .IP_RESET (IP_RESET),
      .bus      (bus)
   );

   // Free-running 10 ns clock
   initial begin
      IP_CLK = 1'b0;
      forever #5 IP_CLK = ~IP_CLK;
   end

   // Hard stop in case something stalls beyond all bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge IP_CLK);
      #1;
   endtask

   task automatic applyStimulus(input int port, input bit valid, input logic [31:0] addr);
      bus.REQ_ADDR[port*33 +: 33] = {valid, addr};
   endtask

   task automatic doReset();
      IP_RESET = 1'b1;
      bus.REQ_ADDR = '0;
      bus.MAXI_RDATA = '0;
      bus.MAXI_RLAST = 1'b0;
      bus.MAXI_RRESP = 2'b00;
      bus.MAXI_ARADDR_ready = 1'b0;
      tick();
      tick();
      IP_RESET = 1'b0;
      errModel = 1'b0;
      lastG = NP - 1;
      #1;
      checkOutput("rstErr", 64'(bus.ERR), 64'd0);
      checkOutput("rstArValid", 64'(bus.MAXI_ARADDR[32]), 64'd0);
      checkOutput("rstRready", 64'(bus.MAXI_RDATA_ready), 64'd0);
      checkOutput("rstReqReady", 64'(bus.REQ_ADDR_ready), 64'd0);
      checkOutput("rstRespValid", 64'({bus.RESP_DATA[129], bus.RESP_DATA[64]}), 64'd0);
   endtask

   // One complete burst for the expected winner; the request is already driven
   task automatic runBurst(input int port, input logic [31:0] addr, input bit dropReq,
                           input bit toggleReady, input int rlastBeat, input int badRespBeat,
                           input int abortBeat, input int tag);
      logic [1:0]  expVec;
      logic [63:0] d;
      logic        rdy;
      logic        rl;
      logic [1:0]  rr;
      int i;
      int cyc;
      bit aborted;
      expVec = 2'b01 << port;
      aborted = 1'b0;
      #1;
      checkOutput("grantReady", 64'(bus.REQ_ADDR_ready), 64'(expVec));
      checkOutput("idleArValid", 64'(bus.MAXI_ARADDR[32]), 64'd0);
      tick();
      if (dropReq) applyStimulus(port, 1'b0, 32'd0);
      if (addr[6:0] != 7'd0) errModel = 1'b1;
      lastG = port;
      bus.RESP_DATA_ready = '1;
      #1;
      checkOutput("arAddr", 64'(bus.MAXI_ARADDR), 64'({1'b1, addr[31:3], 3'b000}));
      checkOutput("arLen", 64'(bus.MAXI_ARLEN), 64'd15);
      checkOutput("arSize", 64'(bus.MAXI_ARSIZE), 64'd3);
      checkOutput("arBurst", 64'(bus.MAXI_ARBURST), 64'd1);
      checkOutput("busyReqReady", 64'(bus.REQ_ADDR_ready), 64'd0);
      checkOutput("addrRready", 64'(bus.MAXI_RDATA_ready), 64'd0);
      checkOutput("errAfterAccept", 64'(bus.ERR), 64'(errModel));
      tick();
      checkOutput("arHold", 64'(bus.MAXI_ARADDR), 64'({1'b1, addr[31:3], 3'b000}));
      bus.MAXI_ARADDR_ready = 1'b1;
      tick();
      bus.MAXI_ARADDR_ready = 1'b0;
      i = 0;
      cyc = 0;
      while (i < BL && cyc < 64) begin
         d  = {32'hC0DE0000 + 32'(tag), 32'(i)};
         rl = (i == rlastBeat);
         rr = (i == badRespBeat) ? 2'b10 : 2'b00;
         rdy = toggleReady ? cyc[0] : 1'b1;
         bus.MAXI_RDATA = {1'b1, d};
         bus.MAXI_RLAST = rl;
         bus.MAXI_RRESP = rr;
         bus.RESP_DATA_ready = '1;
         bus.RESP_DATA_ready[port] = rdy;
         #1;
         checkOutput("respValid", 64'(bus.RESP_DATA[port*65 + 64]), 64'd1);
         checkOutput("respData", bus.RESP_DATA[port*65 +: 64], d);
         checkOutput("otherValid", 64'(bus.RESP_DATA[(1-port)*65 + 64]), 64'd0);
         checkOutput("rreadyMirror", 64'(bus.MAXI_RDATA_ready), 64'(rdy));
         checkOutput("errDuring", 64'(bus.ERR), 64'(errModel));
         checkOutput("dataReqReady", 64'(bus.REQ_ADDR_ready), 64'd0);
         if (i == abortBeat) begin
            IP_RESET = 1'b1;
            tick();
            IP_RESET = 1'b0;
            aborted = 1'b1;
            break;
         end
         tick();
         if (rdy) begin
            if (rr != 2'b00) errModel = 1'b1;
            if (i == BL-1 && !rl) errModel = 1'b1;
            if (i < BL-1 && rl) errModel = 1'b1;
            i++;
         end
         cyc++;
      end
      if (aborted) begin
         errModel = 1'b0;
         lastG = NP - 1;
         #1;
         checkOutput("abortRespValid", 64'({bus.RESP_DATA[129], bus.RESP_DATA[64]}), 64'd0);
         checkOutput("abortRready", 64'(bus.MAXI_RDATA_ready), 64'd0);
         checkOutput("abortArValid", 64'(bus.MAXI_ARADDR[32]), 64'd0);
         checkOutput("abortErr", 64'(bus.ERR), 64'd0);
         bus.MAXI_RDATA = '0;
         bus.MAXI_RLAST = 1'b0;
      end else begin
         checkOutput("beatsDone", 64'(i), 64'(BL));
         bus.MAXI_RDATA = '0;
         bus.MAXI_RLAST = 1'b0;
         bus.MAXI_RRESP = 2'b00;
         #1;
         checkOutput("idleRready", 64'(bus.MAXI_RDATA_ready), 64'd0);
         checkOutput("idleArValid2", 64'(bus.MAXI_ARADDR[32]), 64'd0);
         checkOutput("errEnd", 64'(bus.ERR), 64'(errModel));
      end
   endtask

   // Directed test sequence
   initial begin
      int expPort;
      checkCount = 0;
      errorCount = 0;
      IP_RESET = 1'b1;
      bus.REQ_ADDR = '0;
      bus.RESP_DATA_ready = '0;
      bus.MAXI_ARADDR_ready = 1'b0;
      bus.MAXI_RDATA = '0;
      bus.MAXI_RRESP = 2'b00;
      bus.MAXI_RLAST = 1'b0;
      errModel = 1'b0;
      lastG = NP - 1;
      doReset();

      // No requester: nothing is granted
      tick();
      checkOutput("noReqReady", 64'(bus.REQ_ADDR_ready), 64'd0);
      checkOutput("noReqArValid", 64'(bus.MAXI_ARADDR[32]), 64'd0);

      // Single request on port 0
      applyStimulus(0, 1'b1, 32'h0000_1000);
      runBurst(0, 32'h0000_1000, 1'b1, 1'b0, 15, -1, -1, 1);

      // Backpressure on port 1
      applyStimulus(1, 1'b1, 32'h0000_2000);
      runBurst(1, 32'h0000_2000, 1'b1, 1'b1, 15, -1, -1, 2);

      // Contention: both ports valid continuously, grants must alternate
      applyStimulus(0, 1'b1, 32'h0000_3000);
      applyStimulus(1, 1'b1, 32'h0000_4000);
      for (int n = 0; n < 4; n++) begin
         expPort = (lastG + 1) % NP;
         runBurst(expPort, (expPort == 0) ? 32'h0000_3000 : 32'h0000_4000,
                  1'b0, 1'b0, 15, -1, -1, 10 + n);
      end
      applyStimulus(0, 1'b0, 32'd0);
      applyStimulus(1, 1'b0, 32'd0);
      tick();

      // Early RLAST on beat 5
      applyStimulus(0, 1'b1, 32'h0000_5000);
      runBurst(0, 32'h0000_5000, 1'b1, 1'b0, 5, -1, -1, 20);
      doReset();

      // Error response on beat 3
      applyStimulus(0, 1'b1, 32'h0000_6000);
      runBurst(0, 32'h0000_6000, 1'b1, 1'b0, 15, 3, -1, 21);
      tick();
      checkOutput("errSticky", 64'(bus.ERR), 64'd1);
      doReset();

      // Misaligned address
      applyStimulus(1, 1'b1, 32'h0000_1004);
      runBurst(1, 32'h0000_1004, 1'b1, 1'b0, 15, -1, -1, 22);
      doReset();

      // Reset during beat 8, then a fresh request on port 1
      applyStimulus(0, 1'b1, 32'h0000_7000);
      runBurst(0, 32'h0000_7000, 1'b1, 1'b0, 15, -1, 8, 23);
      tick();
      applyStimulus(1, 1'b1, 32'h0000_8000);
      runBurst(1, 32'h0000_8000, 1'b1, 1'b0, 15, -1, -1, 24);

      tick();
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
